// File: rtl/aes_pkg.sv
// Shared state encoding, round constants and GF(2^8) helpers for the AES-128 cipher datapath.
package aes_pkg;

    localparam int NR_DEFAULT = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul2(input logic [7:0] b);
        return xtime(b);
    endfunction

    function automatic logic [7:0] gf_mul3(input logic [7:0] b);
        return xtime(b) ^ b;
    endfunction

    // Round constants are only defined for rounds 1..10; anything else contributes nothing.
    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] v;
        case (r)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    function automatic logic [3:0] byte_at(input logic [1:0] row, input logic [1:0] col);
        return {col, row};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box as a combinational lookup into a constant table.
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);

    // Entry 0 sits in the top byte, so the lookup indexes with the complement of the input.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign y = SBOX_TABLE[{~a, 3'b000} +: 8];

endmodule

// File: rtl/aes128_enc_iter.sv
// Iterative AES-128 encryption core: one full cipher round per clock with on-the-fly key expansion.
// A single block is in flight between the input and output valid/ready handshakes.
module aes128_enc_iter
    import aes_pkg::*;
#(
    parameter int NR        = NR_DEFAULT,
    parameter bit CLEAR_OUT = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] plaintext,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] ciphertext,
    output logic         busy
);

    state_t       state;
    logic [127:0] st;
    logic [127:0] rk;
    logic [3:0]   rnd;

    logic [127:0] sb;
    logic [127:0] sr;
    logic [127:0] mc;
    logic [127:0] round_out;
    logic [127:0] next_key;
    logic [127:0] next_st;
    logic [31:0]  ksb;
    logic [31:0]  key_temp;
    logic [31:0]  w0, w1, w2, w3;
    logic         last_round;

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[7:0];
        a1 = col[15:8];
        a2 = col[23:16];
        a3 = col[31:24];
        return {gf_mul3(a0) ^ a1 ^ a2 ^ gf_mul2(a3),
                a0 ^ a1 ^ gf_mul2(a2) ^ gf_mul3(a3),
                a0 ^ gf_mul2(a1) ^ gf_mul3(a2) ^ a3,
                gf_mul2(a0) ^ gf_mul3(a1) ^ a2 ^ a3};
    endfunction

    for (genvar i = 0; i < 16; i++) begin : g_sbox
        aes_sbox u_sbox (.a(st[8*i +: 8]), .y(sb[8*i +: 8]));
    end

    // Key schedule only needs the last word of the current round key.
    for (genvar j = 0; j < 4; j++) begin : g_ksbox
        aes_sbox u_ksbox (.a(rk[96 + 8*j +: 8]), .y(ksb[8*j +: 8]));
    end

    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            localparam int DST = int'(byte_at(2'(r), 2'(c)));
            localparam int SRC = int'(byte_at(2'(r), 2'(c + r)));
            assign sr[8*DST +: 8] = sb[8*SRC +: 8];
        end
        assign mc[32*c +: 32] = mix_column(sr[32*c +: 32]);
    end

    assign last_round = (rnd == 4'(NR));
    assign key_temp   = {ksb[7:0], ksb[31:24], ksb[23:16], ksb[15:8]} ^ {24'd0, rcon(rnd)};
    assign w0         = rk[31:0]   ^ key_temp;
    assign w1         = rk[63:32]  ^ w0;
    assign w2         = rk[95:64]  ^ w1;
    assign w3         = rk[127:96] ^ w2;
    assign next_key   = {w3, w2, w1, w0};
    assign round_out  = last_round ? sr : mc;
    assign next_st    = round_out ^ next_key;

    // Control, datapath registers and all outputs share one register stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            st         <= '0;
            rk         <= '0;
            rnd        <= '0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            ciphertext <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        st       <= plaintext ^ key;
                        rk       <= key;
                        rnd      <= 4'd1;
                        state    <= ROUND;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                ROUND: begin
                    st <= next_st;
                    rk <= next_key;
                    if (last_round) begin
                        state      <= DONE;
                        out_valid  <= 1'b1;
                        ciphertext <= next_st;
                    end else begin
                        rnd <= rnd + 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        if (CLEAR_OUT) begin
                            ciphertext <= '0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes128_enc_iter.sv
// Bench for the iterative AES-128 core: textbook AES model with a per-cycle handshake/latency model,
// FIPS-197 vectors, backpressure, held in_valid, mid-flight reset and randomized blocks.
module tb_aes128_enc_iter;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] plaintext = '0;
    logic [127:0] key = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [127:0] ciphertext;
    logic         busy;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    int errors = 0;
    int checks = 0;

    logic [7:0]   sbox_tab [256];
    bit           m_busy = 1'b0;
    bit           m_outv = 1'b0;
    int           m_cnt = 0;
    logic [127:0] m_ct = '0;
    int           cycle = 0;
    int           accept_cycle = 0;

    aes128_enc_iter dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .plaintext  (plaintext),
        .key        (key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ciphertext (ciphertext),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // S-box from first principles: multiplicative inverse followed by the affine map.
    function automatic logic [7:0] sbox_entry(input int x);
        logic [7:0] inv;
        inv = 8'h00;
        for (int y = 1; y < 256; y++) begin
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // FIPS-197 hex strings list byte 0 first; the ports carry byte 0 in bits [7:0].
    function automatic logic [127:0] fips(input logic [127:0] v);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = v[8*(15-i) +: 8];
        return o;
    endfunction

    function automatic logic [127:0] aes_model(input logic [127:0] pt, input logic [127:0] k);
        logic [7:0]   w [44][4];
        logic [7:0]   s [4][4];
        logic [7:0]   t [4][4];
        logic [7:0]   tmp [4];
        logic [7:0]   rc, x, acc;
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) w[i][j] = k[8*(4*i+j) +: 8];
        for (int i = 4; i < 44; i++) begin
            for (int j = 0; j < 4; j++) tmp[j] = w[i-1][j];
            if (i % 4 == 0) begin
                x = tmp[0];
                tmp[0] = sbox_tab[tmp[1]] ^ rc;
                tmp[1] = sbox_tab[tmp[2]];
                tmp[2] = sbox_tab[tmp[3]];
                tmp[3] = sbox_tab[x];
                rc = gmul(rc, 8'h02);
            end
            for (int j = 0; j < 4; j++) w[i][j] = w[i-4][j] ^ tmp[j];
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) s[r][c] = pt[8*(r+4*c) +: 8] ^ w[c][r];
        for (int rd = 1; rd <= 10; rd++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) t[r][c] = sbox_tab[s[r][(c+r)%4]];
            for (int c = 0; c < 4; c++) begin
                for (int r = 0; r < 4; r++) begin
                    if (rd == 10) begin
                        acc = t[r][c];
                    end else begin
                        acc = 8'h00;
                        for (int q = 0; q < 4; q++) begin
                            acc = acc ^ gmul(((q - r) & 3) == 0 ? 8'h02 :
                                             ((q - r) & 3) == 1 ? 8'h03 : 8'h01, t[q][c]);
                        end
                    end
                    s[r][c] = acc ^ w[4*rd+c][r];
                end
            end
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) res[8*(r+4*c) +: 8] = s[r][c];
        return res;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at cycle %0d", name, actual, expected, cycle);
        end
    endtask

    task automatic applyStimulus(input logic [127:0] pt, input logic [127:0] k);
        int n;
        @(negedge clk);
        plaintext = pt;
        key       = k;
        in_valid  = 1'b1;
        n = 0;
        while (!in_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) checkOutput("accept_timeout", 128'd0, 128'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic waitResult(input string name, input logic [127:0] exp_fips);
        int n;
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) checkOutput({name, "_timeout"}, 128'd0, 128'd1);
        checkOutput({name, "_ct"}, ciphertext, fips(exp_fips));
        checkOutput({name, "_latency"}, 128'(cycle - accept_cycle), 128'd10);
    endtask

    // Cycle-level expectation: a block is accepted only while idle, completes ten edges later
    // and stays presented until the consumer takes it.
    always @(posedge clk) begin
        cycle++;
        if (rst) begin
            m_busy = 1'b0;
            m_outv = 1'b0;
            m_ct   = '0;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_busy = 1'b1;
                m_cnt  = 0;
                m_ct   = aes_model(plaintext, key);
                accept_cycle = cycle;
            end
        end else if (!m_outv) begin
            m_cnt++;
            if (m_cnt == 10) m_outv = 1'b1;
        end else if (out_ready) begin
            m_busy = 1'b0;
            m_outv = 1'b0;
        end
    end

    always @(negedge clk) begin
        checkOutput("out_valid", {127'd0, out_valid}, {127'd0, m_outv});
        checkOutput("in_ready", {127'd0, in_ready}, {127'd0, !m_busy});
        checkOutput("busy", {127'd0, busy}, {127'd0, m_busy});
        checkOutput("ciphertext", ciphertext, m_outv ? m_ct : 128'd0);
    end

    initial begin
        int n;
        for (int x = 0; x < 256; x++) sbox_tab[x] = sbox_entry(x);

        checkOutput("pin_sbox_00", {120'd0, sbox_tab[8'h00]}, 128'h63);
        checkOutput("pin_sbox_53", {120'd0, sbox_tab[8'h53]}, 128'hed);
        checkOutput("pin_model_c1", aes_model(fips(C1_PT), fips(C1_KEY)), fips(C1_CT));
        checkOutput("pin_model_b", aes_model(fips(B_PT), fips(B_KEY)), fips(B_CT));
        checkOutput("pin_model_zero", aes_model(128'd0, 128'd0), fips(Z_CT));

        repeat (3) @(negedge clk);
        checkOutput("reset_in_ready", {127'd0, in_ready}, 128'd1);
        checkOutput("reset_out_valid", {127'd0, out_valid}, 128'd0);
        checkOutput("reset_busy", {127'd0, busy}, 128'd0);
        checkOutput("reset_ct", ciphertext, 128'd0);
        rst = 1'b0;

        $display("[TB] FIPS-197 vectors");
        applyStimulus(fips(C1_PT), fips(C1_KEY));
        waitResult("vec_c1", C1_CT);
        @(negedge clk);
        applyStimulus(fips(B_PT), fips(B_KEY));
        waitResult("vec_b", B_CT);
        @(negedge clk);

        $display("[TB] Backpressure");
        out_ready = 1'b0;
        applyStimulus(fips(C1_PT), fips(C1_KEY));
        waitResult("bp", C1_CT);
        repeat (7) begin
            @(negedge clk);
            checkOutput("bp_hold_ct", ciphertext, fips(C1_CT));
            checkOutput("bp_hold_valid", {127'd0, out_valid}, 128'd1);
            checkOutput("bp_hold_in_ready", {127'd0, in_ready}, 128'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_release_in_ready", {127'd0, in_ready}, 128'd1);
        checkOutput("bp_release_valid", {127'd0, out_valid}, 128'd0);

        $display("[TB] in_valid held through rounds");
        @(negedge clk);
        plaintext = fips(C1_PT);
        key       = fips(C1_KEY);
        in_valid  = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            plaintext = {$urandom, $urandom, $urandom, $urandom};
            key       = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
        end
        waitResult("held", C1_CT);
        @(negedge clk);
        checkOutput("b2b_idle_after_hs", {127'd0, in_ready}, 128'd1);
        @(negedge clk);
        checkOutput("b2b_accept_next", {127'd0, busy}, 128'd1);
        repeat (14) @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (m_busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) checkOutput("b2b_drain_timeout", 128'd0, 128'd1);

        $display("[TB] Reset mid-flight");
        applyStimulus(fips(B_PT), fips(B_KEY));
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_out_valid", {127'd0, out_valid}, 128'd0);
        checkOutput("midrst_in_ready", {127'd0, in_ready}, 128'd1);
        checkOutput("midrst_ct", ciphertext, 128'd0);
        rst = 1'b0;
        applyStimulus(fips(C1_PT), fips(C1_KEY));
        waitResult("after_rst", C1_CT);
        @(negedge clk);

        $display("[TB] All-zero block");
        applyStimulus(128'd0, 128'd0);
        waitResult("zero", Z_CT);
        checkOutput("zero_byte0", {120'd0, ciphertext[7:0]}, 128'h66);
        @(negedge clk);

        $display("[TB] Randomized blocks");
        for (int b = 0; b < 25; b++) begin
            applyStimulus({$urandom, $urandom, $urandom, $urandom},
                          {$urandom, $urandom, $urandom, $urandom});
            n = 0;
            while (m_busy && n < 200) begin
                @(negedge clk);
                out_ready = 1'($urandom_range(0, 1));
                n++;
            end
            if (n >= 200) checkOutput("rand_timeout", 128'd0, 128'd1);
            out_ready = 1'b1;
        end

        repeat (2) @(negedge clk);
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
